somador_serial_ctrl: RTL and testbench
======================================

// Module: somador_serial_ctrl
// PURPOSE
//   Bit-serial N-bit adder controller built around one somador_1bit (A, B, Te -> S, Ts).
//   Latches two operands, feeds one bit pair per clock LSB-first, recirculates the carry
//   through a flip-flop and assembles the N-bit sum. Start/busy/done handshake.
//   Sits between operand registers and any consumer needing a low-area adder.
// PARAMETERS
//   N  8  operand/result width in bits (N >= 2); counter width = $clog2(N)+1
// PORTS
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous reset, active-high
//   inicio   in   1  start request, sampled only in OCIOSO
//   A        in   N  operand A, captured on accepted inicio
//   B        in   N  operand B, captured on accepted inicio
//   sub      in   1  subtract select (present only with SOMADOR_SUB_EN)
//   S        out  N  result, registered, held until next completion
//   Ts       out  1  final carry-out of bit N-1, registered with S
//   ocupado  out  1  high while in CALCULA
//   pronto   out  1  one-cycle pulse, result valid
// BEHAVIOUR
//   - Reset (async, any state): state=OCIOSO; S=0, Ts=0, ocupado=0, pronto=0;
//     shift regs, carry FF and counter cleared. Reset mid-CALCULA aborts, no pronto.
//   - FSM OCIOSO -> CALCULA -> FIM -> OCIOSO.
//   - OCIOSO: on clk edge with inicio=1: ra<=A, rb<=B, carry<=0, cnt<=0, go CALCULA.
//     inicio=0: stay. Outputs S/Ts keep previous result.
//   - CALCULA: one somador_1bit instance: A=ra[0], B=rb[0], Te=carry.
//     Each edge: ra,rb shift right; sum bit enters rs[N-1] (rs shifts right);
//     carry<=Ts of cell; cnt<=cnt+1. When cnt==N-1 at the edge: go FIM and load
//     S<=final assembled rs (including this edge's bit), Ts<=cell Ts.
//   - FIM: pronto=1 for exactly this cycle; unconditional return to OCIOSO next edge.
//   - Latency: inicio sampled at edge k -> CALCULA at edges k+1..k+N ->
//     pronto high in the cycle following edge k+N. Back-to-back: next inicio
//     accepted no earlier than edge k+N+2 (first OCIOSO cycle).
//   - inicio while CALCULA or FIM: ignored, no queuing; A/B changes then ignored.
//   - Arithmetic: unsigned mod 2^N; Ts = bit N of A+B. No overflow flag.
//   - ocupado and pronto are Moore outputs decoded from state (glitch-free, registered state).
// CONFIGURATION
//   SOMADOR_SUB_EN defined: port sub exists; on accepted inicio with sub=1,
//     rb<=~B and carry<=1, giving S=A-B mod 2^N, Ts=1 means no borrow (A>=B).
//     sub=0 behaves exactly as plain addition. sub sampled only with inicio.
//   SOMADOR_SUB_EN undefined: no sub port; addition only; carry always starts at 0.
// TESTING (N=8 unless stated)
//   1. A=0x05,B=0x03,inicio 1 cycle -> ocupado 8 cycles, pronto pulse, S=0x08, Ts=0.
//   2. A=0xFF,B=0x01 -> S=0x00, Ts=1; A=0xFF,B=0xFF -> S=0xFE, Ts=1.
//   3. Start A=0x10,B=0x20; pulse inicio with A=0xAA,B=0x55 during CALCULA
//      -> ignored; S=0x30, Ts=0; exactly one pronto.
//   4. Start A=0x7F,B=0x01; assert rst at cycle 4 of CALCULA -> immediately
//      S=0, Ts=0, ocupado=0, no pronto; fresh start A=0x02,B=0x02 -> S=0x04.
//   5. Hold inicio high permanently, A=0x01,B=0x01 -> ops repeat every N+2 cycles,
//      S=0x02 each time, pronto spacing exactly 10 cycles.
//   6. SOMADOR_SUB_EN: sub=1, A=0x05,B=0x03 -> S=0x02,Ts=1; A=0x03,B=0x05
//      -> S=0xFE,Ts=0. Also N=2 build: exhaustive 16 add pairs vs A+B model.

Source files
------------

// File: rtl/somador_serial_ctrl.sv
// Bit-serial N-bit adder: one full-adder cell, carry recirculated through a flip-flop, LSB first.
// Optional subtraction (port sub, B inverted with carry-in 1) when SOMADOR_SUB_EN is defined.

module somador_1bit (
  input  logic A,
  input  logic B,
  input  logic Te,
  output logic S,
  output logic Ts
);
  assign S  = A ^ B ^ Te;
  assign Ts = (A & B) | (Te & (A ^ B));
endmodule

module somador_serial_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inicio,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
`ifdef SOMADOR_SUB_EN
  input  logic         sub,
`endif
  output logic [N-1:0] S,
  output logic         Ts,
  output logic         ocupado,
  output logic         pronto
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {OCIOSO, CALCULA, FIM} estado_t;

  estado_t         state_reg, state_next;
  logic [N-1:0]    ra_reg, rb_reg;
  logic [N-2:0]    rs_reg;
  logic            carry_reg;
  logic [CW-1:0]   cnt_reg;
  logic [N-1:0]    s_reg;
  logic            ts_reg;
  logic            cell_s, cell_ts;
  logic [N-1:0]    sum_full;
  logic            last_bit;
  logic            sub_sel;

`ifdef SOMADOR_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  somador_1bit u_cell (
    .A  (ra_reg[0]),
    .B  (rb_reg[0]),
    .Te (carry_reg),
    .S  (cell_s),
    .Ts (cell_ts)
  );

  // Previously produced bits plus the bit being produced this cycle.
  assign sum_full = {cell_s, rs_reg};
  assign last_bit = (cnt_reg == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= OCIOSO;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ocupado    = 1'b0;
    pronto     = 1'b0;
    case (state_reg)
      OCIOSO:  if (inicio) state_next = CALCULA;
      CALCULA: begin
        ocupado = 1'b1;
        if (last_bit) state_next = FIM;
      end
      FIM: begin
        pronto     = 1'b1;
        state_next = OCIOSO;
      end
      default: state_next = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_reg    <= '0;
      rb_reg    <= '0;
      rs_reg    <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      s_reg     <= '0;
      ts_reg    <= 1'b0;
    end else begin
      case (state_reg)
        OCIOSO: begin
          if (inicio) begin
            ra_reg    <= A;
            rb_reg    <= sub_sel ? ~B : B;
            carry_reg <= sub_sel;
            cnt_reg   <= '0;
          end
        end
        CALCULA: begin
          ra_reg    <= ra_reg >> 1;
          rb_reg    <= rb_reg >> 1;
          rs_reg    <= sum_full[N-1:1];
          carry_reg <= cell_ts;
          cnt_reg   <= cnt_reg + 1'b1;
          if (last_bit) begin
            s_reg  <= sum_full;
            ts_reg <= cell_ts;
          end
        end
        default: ;
      endcase
    end
  end

  assign S  = s_reg;
  assign Ts = ts_reg;
endmodule

// File: tb/tb_somador_serial_ctrl.sv
// Self-checking bench for somador_serial_ctrl (N=8): timing/arithmetic model checked every cycle
// plus directed literal expectations. Define SOMADOR_SUB_EN to also exercise subtraction.

module tb_somador_serial_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         inicio;
  logic [N-1:0] A, B;
  logic         sub;
  logic [N-1:0] S;
  logic         Ts, ocupado, pronto;

  int checks = 0;
  int errors = 0;

  somador_serial_ctrl #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .inicio  (inicio),
    .A       (A),
    .B       (B),
`ifdef SOMADOR_SUB_EN
    .sub     (sub),
`endif
    .S       (S),
    .Ts      (Ts),
    .ocupado (ocupado),
    .pronto  (pronto)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: an accepted start at edge k means busy after edges k..k+N-1, pronto after
  // edge k+N, result visible from edge k+N on, and the next start accepted from k+N+2.
  int           edge_cnt = 0;
  int           k_edge = 0;
  int           free_edge = 0;
  bit           op_active = 0;
  logic [N:0]   exp_val;
  logic [N-1:0] s_exp = '0;
  logic         ts_exp = 1'b0;
  logic         sub_eff;

  always @(posedge clk) begin
    edge_cnt++;
    if (rst) begin
      op_active = 0;
      s_exp     = '0;
      ts_exp    = 1'b0;
      free_edge = edge_cnt + 1;
    end else begin
      if (op_active && edge_cnt == k_edge + N) begin
        s_exp  = exp_val[N-1:0];
        ts_exp = exp_val[N];
      end
      if (edge_cnt >= free_edge && inicio) begin
`ifdef SOMADOR_SUB_EN
        sub_eff = sub;
`else
        sub_eff = 1'b0;
`endif
        if (sub_eff) exp_val = {(A >= B), A - B};
        else         exp_val = {1'b0, A} + {1'b0, B};
        op_active = 1;
        k_edge    = edge_cnt;
        free_edge = edge_cnt + N + 2;
      end
    end
  end

  int pronto_count = 0;
  int busy_count   = 0;
  int pr_times[$];

  always @(posedge clk) begin
    #1;
    chk("ocupado", 32'(ocupado), 32'(op_active && edge_cnt >= k_edge && edge_cnt < k_edge + N));
    chk("pronto",  32'(pronto),  32'(op_active && edge_cnt == k_edge + N));
    chk("S",       32'(S),       32'(s_exp));
    chk("Ts",      32'(Ts),      32'(ts_exp));
    if (pronto) begin
      pronto_count++;
      pr_times.push_back(edge_cnt);
    end
    if (ocupado) busy_count++;
  end

  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    repeat (2) @(negedge clk);
    A = a; B = b; sub = s; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    $display("start A=%0h B=%0h sub=%0b", a, b, s);
  endtask

  task automatic wait_pronto(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #2;
      if (pronto) seen = 1;
    end
    chk({name, "_timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic s, input logic [N-1:0] s_lit, input logic ts_lit);
    start_op(a, b, s);
    wait_pronto(name);
    chk({name, "_S"}, 32'(S), 32'(s_lit));
    chk({name, "_Ts"}, 32'(Ts), 32'(ts_lit));
    $display("op %s: S=%0h Ts=%0b", name, S, Ts);
  endtask

  int pc0, bc0;

  initial begin
    rst = 1'b1; inicio = 1'b0; A = '0; B = '0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_pronto", 32'(pronto), 32'd0);
    rst = 1'b0;

    bc0 = busy_count;
    run_op("add_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
    chk("busy_cycles", 32'(busy_count - bc0), 32'd8);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("add_ff_ff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);
    run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    run_op("add_5a_a5", 8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0);

    // Start request during the calculation must be dropped.
    pc0 = pronto_count;
    start_op(8'h10, 8'h20, 1'b0);
    repeat (3) @(negedge clk);
    A = 8'hAA; B = 8'h55; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    wait_pronto("ignore");
    chk("ignore_S", 32'(S), 32'h30);
    chk("ignore_Ts", 32'(Ts), 32'd0);
    repeat (15) @(negedge clk);
    chk("ignore_one_pronto", 32'(pronto_count - pc0), 32'd1);

    // Asynchronous reset in the 4th busy cycle aborts the operation.
    pc0 = pronto_count;
    start_op(8'h7F, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_S", 32'(S), 32'd0);
    chk("abort_Ts", 32'(Ts), 32'd0);
    chk("abort_ocupado", 32'(ocupado), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_no_pronto", 32'(pronto_count - pc0), 32'd0);
    run_op("after_abort", 8'h02, 8'h02, 1'b0, 8'h04, 1'b0);

    // inicio held high: operations repeat every N+2 cycles.
    @(negedge clk);
    pr_times.delete();
    A = 8'h01; B = 8'h01; sub = 1'b0; inicio = 1'b1;
    repeat (45) @(negedge clk);
    inicio = 1'b0;
    chk("hold_S", 32'(S), 32'h02);
    chk("hold_pulses", 32'(pr_times.size() >= 4), 32'd1);
    for (int i = 1; i < pr_times.size(); i++)
      chk("hold_spacing", 32'(pr_times[i] - pr_times[i-1]), 32'd10);
    $display("hold: %0d pronto pulses", pr_times.size());
    repeat (12) @(negedge clk);

`ifdef SOMADOR_SUB_EN
    run_op("sub_05_03", 8'h05, 8'h03, 1'b1, 8'h02, 1'b1);
    run_op("sub_03_05", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0);
    run_op("sub0_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
`endif

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
